// File: rtl/cache_mem_if_pkg.sv
// Channel payload types of the cache_mem_if memory port, shared by the
// arbiter and everything that connects to it.
package cache_mem_if_pkg;

    localparam int CACHE_MEM_ID_W = 8;

    typedef struct packed {
        logic [CACHE_MEM_ID_W-1:0] id;
        logic [31:0]               addr;
        logic [7:0]                len;
        logic [2:0]                size;
        logic [1:0]                burst;
    } cache_mem_if_aw_t;

    typedef struct packed {
        logic [CACHE_MEM_ID_W-1:0] id;
        logic [31:0]               addr;
        logic [7:0]                len;
        logic [2:0]                size;
        logic [1:0]                burst;
    } cache_mem_if_ar_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } cache_mem_if_w_t;

    typedef struct packed {
        logic [CACHE_MEM_ID_W-1:0] id;
        logic [63:0]               data;
        logic [1:0]                resp;
        logic                      last;
    } cache_mem_if_r_t;

    typedef struct packed {
        logic [CACHE_MEM_ID_W-1:0] id;
        logic [1:0]                resp;
    } cache_mem_if_b_t;

endpackage

// File: rtl/cache_mem_arb.sv
// N_REQ-to-1 cache_mem_if arbiter: round-robin AR/AW, W steered in AW order,
// R/B routed by a source tag in the upper ID bits. Optional: CACHE_MEM_ARB_PERF_EN.
module cache_mem_arb
    import cache_mem_if_pkg::*;
#(
    parameter int N_REQ        = 2,
    parameter int SRC_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    parameter int ID_W         = CACHE_MEM_ID_W,
    parameter int W_FIFO_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic [N_REQ-1:0]             s_awvalid,
    output logic [N_REQ-1:0]             s_awready,
    input  cache_mem_if_aw_t [N_REQ-1:0] s_aw,
    input  logic [N_REQ-1:0]             s_wvalid,
    output logic [N_REQ-1:0]             s_wready,
    input  cache_mem_if_w_t [N_REQ-1:0]  s_w,
    input  logic [N_REQ-1:0]             s_arvalid,
    output logic [N_REQ-1:0]             s_arready,
    input  cache_mem_if_ar_t [N_REQ-1:0] s_ar,
    output logic [N_REQ-1:0]             s_rvalid,
    input  logic [N_REQ-1:0]             s_rready,
    output cache_mem_if_r_t [N_REQ-1:0]  s_r,
    output logic [N_REQ-1:0]             s_bvalid,
    input  logic [N_REQ-1:0]             s_bready,
    output cache_mem_if_b_t [N_REQ-1:0]  s_b,

    output logic                         m_awvalid,
    input  logic                         m_awready,
    output cache_mem_if_aw_t             m_aw,
    output logic                         m_wvalid,
    input  logic                         m_wready,
    output cache_mem_if_w_t              m_w,
    output logic                         m_arvalid,
    input  logic                         m_arready,
    output cache_mem_if_ar_t             m_ar,
    input  logic                         m_rvalid,
    output logic                         m_rready,
    input  cache_mem_if_r_t              m_r,
    input  logic                         m_bvalid,
    output logic                         m_bready,
    input  cache_mem_if_b_t              m_b,

    output logic                         err_bad_src
`ifdef CACHE_MEM_ARB_PERF_EN
    ,
    output logic [N_REQ-1:0][31:0]       perf_ar_cnt,
    output logic [N_REQ-1:0][31:0]       perf_aw_cnt
`endif
);

    localparam int FA_W = $clog2(W_FIFO_DEPTH);
    localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(N_REQ - 1);
    localparam logic [FA_W:0] FIFO_FULL_CNT = (FA_W + 1)'(W_FIFO_DEPTH);

    // Returns {found, index}: first requester at or above ptr, else the lowest one.
    function automatic logic [SRC_W:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [SRC_W-1:0] ptr);
        logic [SRC_W-1:0] hi;
        logic [SRC_W-1:0] lo;
        logic             found_hi;
        logic             found_lo;
        hi       = '0;
        lo       = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo       = SRC_W'(i);
                found_lo = 1'b1;
                if (SRC_W'(i) >= ptr) begin
                    hi       = SRC_W'(i);
                    found_hi = 1'b1;
                end
            end
        end
        return found_hi ? {1'b1, hi} : {found_lo, lo};
    endfunction

    function automatic logic [ID_W-1:0] tag_id(input logic [SRC_W-1:0] src,
                                               input logic [ID_W-1:0]  id);
        return {src, id[ID_W-SRC_W-1:0]};
    endfunction

    function automatic logic [ID_W-1:0] untag_id(input logic [ID_W-1:0] id);
        return {{SRC_W{1'b0}}, id[ID_W-SRC_W-1:0]};
    endfunction

    // ---------------- AR channel ----------------
    logic [SRC_W-1:0] ar_ptr, ar_lock_src, ar_pick, ar_gnt;
    logic             ar_locked, ar_found, ar_valid, ar_hs;
    cache_mem_if_ar_t ar_sel;

    always_comb begin
        {ar_found, ar_pick} = rr_pick(s_arvalid, ar_ptr);
        ar_gnt    = ar_locked ? ar_lock_src : ar_pick;
        ar_valid  = 1'b0;
        ar_sel    = '0;
        s_arready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ar_gnt == SRC_W'(i)) begin
                ar_valid     = s_arvalid[i] & ~rst;
                ar_sel       = s_ar[i];
                s_arready[i] = m_arready & s_arvalid[i] & ~rst;
            end
        end
        m_arvalid = ar_valid;
        m_ar      = ar_sel;
        m_ar.id   = tag_id(ar_gnt, ar_sel.id);
        ar_hs     = ar_valid & m_arready;
    end

    // A stalled grant is frozen so the downstream payload cannot change mid-handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            ar_ptr      <= '0;
            ar_locked   <= 1'b0;
            ar_lock_src <= '0;
        end else if (ar_hs) begin
            ar_ptr    <= (ar_gnt == LAST_SRC) ? '0 : ar_gnt + 1'b1;
            ar_locked <= 1'b0;
        end else if (ar_valid) begin
            ar_locked   <= 1'b1;
            ar_lock_src <= ar_gnt;
        end
    end

    // ---------------- AW channel + W order FIFO ----------------
    logic [SRC_W-1:0] aw_ptr, aw_lock_src, aw_pick, aw_gnt;
    logic             aw_locked, aw_found, aw_valid, aw_hs;
    cache_mem_if_aw_t aw_sel;

    logic [SRC_W-1:0] fifo_mem [W_FIFO_DEPTH];
    logic [FA_W-1:0]  fifo_wp, fifo_rp;
    logic [FA_W:0]    fifo_cnt;
    logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [SRC_W-1:0] w_head;
    logic             w_hs;

    assign fifo_full  = (fifo_cnt == FIFO_FULL_CNT);
    assign fifo_empty = (fifo_cnt == '0);
    assign w_head     = fifo_mem[fifo_rp];

    always_comb begin
        {aw_found, aw_pick} = rr_pick(s_awvalid, aw_ptr);
        aw_gnt    = aw_locked ? aw_lock_src : aw_pick;
        aw_valid  = 1'b0;
        aw_sel    = '0;
        s_awready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (aw_gnt == SRC_W'(i)) begin
                aw_valid     = s_awvalid[i] & ~fifo_full & ~rst;
                aw_sel       = s_aw[i];
                s_awready[i] = m_awready & s_awvalid[i] & ~fifo_full & ~rst;
            end
        end
        m_awvalid = aw_valid;
        m_aw      = aw_sel;
        m_aw.id   = tag_id(aw_gnt, aw_sel.id);
        aw_hs     = aw_valid & m_awready;
        fifo_push = aw_hs;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_ptr      <= '0;
            aw_locked   <= 1'b0;
            aw_lock_src <= '0;
        end else if (aw_hs) begin
            aw_ptr    <= (aw_gnt == LAST_SRC) ? '0 : aw_gnt + 1'b1;
            aw_locked <= 1'b0;
        end else if (aw_valid) begin
            aw_locked   <= 1'b1;
            aw_lock_src <= aw_gnt;
        end
    end

    // W only follows an entry already in the FIFO, so the first beat trails its AW by a cycle.
    always_comb begin
        m_wvalid = 1'b0;
        m_w      = '0;
        s_wready = '0;
        if (!fifo_empty && !rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (w_head == SRC_W'(i)) begin
                    m_wvalid    = s_wvalid[i];
                    m_w         = s_w[i];
                    s_wready[i] = m_wready;
                end
            end
        end
        w_hs     = m_wvalid & m_wready;
        fifo_pop = w_hs & m_w.last;
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[fifo_wp] <= aw_gnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_wp  <= '0;
            fifo_rp  <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_push) fifo_wp <= fifo_wp + 1'b1;
            if (fifo_pop)  fifo_rp <= fifo_rp + 1'b1;
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // ---------------- R / B routing ----------------
    logic [SRC_W-1:0] r_src, b_src;
    logic             r_bad, b_bad;

    assign r_src = m_r.id[ID_W-1 -: SRC_W];
    assign b_src = m_b.id[ID_W-1 -: SRC_W];

    // A tag matching no requester is sunk so the downstream cannot wedge.
    always_comb begin
        s_rvalid = '0;
        m_rready = 1'b0;
        r_bad    = 1'b1;
        for (int i = 0; i < N_REQ; i++) begin
            s_r[i]    = m_r;
            s_r[i].id = untag_id(m_r.id);
            if (r_src == SRC_W'(i)) begin
                r_bad       = 1'b0;
                s_rvalid[i] = m_rvalid & ~rst;
                m_rready    = s_rready[i] & ~rst;
            end
        end
        if (r_bad) m_rready = ~rst;
    end

    always_comb begin
        s_bvalid = '0;
        m_bready = 1'b0;
        b_bad    = 1'b1;
        for (int i = 0; i < N_REQ; i++) begin
            s_b[i]    = m_b;
            s_b[i].id = untag_id(m_b.id);
            if (b_src == SRC_W'(i)) begin
                b_bad       = 1'b0;
                s_bvalid[i] = m_bvalid & ~rst;
                m_bready    = s_bready[i] & ~rst;
            end
        end
        if (b_bad) m_bready = ~rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_bad_src <= 1'b0;
        end else if ((m_rvalid && r_bad) || (m_bvalid && b_bad)) begin
            err_bad_src <= 1'b1;
        end
    end

`ifdef CACHE_MEM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (rst) begin
                perf_ar_cnt[i] <= '0;
                perf_aw_cnt[i] <= '0;
            end else begin
                if (ar_hs && ar_gnt == SRC_W'(i) && perf_ar_cnt[i] != 32'hFFFF_FFFF)
                    perf_ar_cnt[i] <= perf_ar_cnt[i] + 32'd1;
                if (aw_hs && aw_gnt == SRC_W'(i) && perf_aw_cnt[i] != 32'hFFFF_FFFF)
                    perf_aw_cnt[i] <= perf_aw_cnt[i] + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_mem_arb.sv
// Directed bench for cache_mem_arb: a 2-requester instance for arbitration,
// W ordering and routing, plus a 3-requester instance for the bad-tag path.
module tb_cache_mem_arb;
    import cache_mem_if_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---- N_REQ = 2 instance ----
    logic [1:0]             s_awvalid, s_awready, s_wvalid, s_wready;
    logic [1:0]             s_arvalid, s_arready, s_rvalid, s_rready;
    logic [1:0]             s_bvalid, s_bready;
    cache_mem_if_aw_t [1:0] s_aw;
    cache_mem_if_w_t [1:0]  s_w;
    cache_mem_if_ar_t [1:0] s_ar;
    cache_mem_if_r_t [1:0]  s_r;
    cache_mem_if_b_t [1:0]  s_b;
    logic m_awvalid, m_awready, m_wvalid, m_wready, m_arvalid, m_arready;
    logic m_rvalid, m_rready, m_bvalid, m_bready, err_bad_src;
    cache_mem_if_aw_t m_aw;
    cache_mem_if_w_t  m_w;
    cache_mem_if_ar_t m_ar;
    cache_mem_if_r_t  m_r;
    cache_mem_if_b_t  m_b;
`ifdef CACHE_MEM_ARB_PERF_EN
    logic [1:0][31:0] perf_ar_cnt, perf_aw_cnt;
    logic [2:0][31:0] t3_perf_ar_cnt, t3_perf_aw_cnt;
`endif

    // ---- N_REQ = 3 instance ----
    logic [2:0]             t3_s_awvalid, t3_s_awready, t3_s_wvalid, t3_s_wready;
    logic [2:0]             t3_s_arvalid, t3_s_arready, t3_s_rvalid, t3_s_rready;
    logic [2:0]             t3_s_bvalid, t3_s_bready;
    cache_mem_if_aw_t [2:0] t3_s_aw;
    cache_mem_if_w_t [2:0]  t3_s_w;
    cache_mem_if_ar_t [2:0] t3_s_ar;
    cache_mem_if_r_t [2:0]  t3_s_r;
    cache_mem_if_b_t [2:0]  t3_s_b;
    logic t3_m_awvalid, t3_m_wvalid, t3_m_arvalid, t3_m_rready, t3_m_bready;
    logic t3_m_bvalid, t3_err_bad_src;
    cache_mem_if_aw_t t3_m_aw;
    cache_mem_if_w_t  t3_m_w;
    cache_mem_if_ar_t t3_m_ar;
    cache_mem_if_b_t  t3_m_b;

    cache_mem_arb #(.N_REQ(2)) dut (
        .clk(clk), .rst(rst),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_aw(s_aw),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_w(s_w),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_ar(s_ar),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_r(s_r),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_b(s_b),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_aw(m_aw),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_w(m_w),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_ar(m_ar),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_r(m_r),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_b(m_b),
        .err_bad_src(err_bad_src)
`ifdef CACHE_MEM_ARB_PERF_EN
        , .perf_ar_cnt(perf_ar_cnt), .perf_aw_cnt(perf_aw_cnt)
`endif
    );

    cache_mem_arb #(.N_REQ(3)) dut3 (
        .clk(clk), .rst(rst),
        .s_awvalid(t3_s_awvalid), .s_awready(t3_s_awready), .s_aw(t3_s_aw),
        .s_wvalid(t3_s_wvalid), .s_wready(t3_s_wready), .s_w(t3_s_w),
        .s_arvalid(t3_s_arvalid), .s_arready(t3_s_arready), .s_ar(t3_s_ar),
        .s_rvalid(t3_s_rvalid), .s_rready(t3_s_rready), .s_r(t3_s_r),
        .s_bvalid(t3_s_bvalid), .s_bready(t3_s_bready), .s_b(t3_s_b),
        .m_awvalid(t3_m_awvalid), .m_awready(1'b0), .m_aw(t3_m_aw),
        .m_wvalid(t3_m_wvalid), .m_wready(1'b0), .m_w(t3_m_w),
        .m_arvalid(t3_m_arvalid), .m_arready(1'b0), .m_ar(t3_m_ar),
        .m_rvalid(1'b0), .m_rready(t3_m_rready), .m_r('0),
        .m_bvalid(t3_m_bvalid), .m_bready(t3_m_bready), .m_b(t3_m_b),
        .err_bad_src(t3_err_bad_src)
`ifdef CACHE_MEM_ARB_PERF_EN
        , .perf_ar_cnt(t3_perf_ar_cnt), .perf_aw_cnt(t3_perf_aw_cnt)
`endif
    );

    // ---- scoreboard ----
    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        s_awvalid = '0; s_wvalid = '0; s_arvalid = '0; s_rready = '0; s_bready = '0;
        s_aw = '0; s_w = '0; s_ar = '0;
        m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
        m_rvalid = 1'b0; m_bvalid = 1'b0; m_r = '0; m_b = '0;
        t3_s_awvalid = '0; t3_s_wvalid = '0; t3_s_arvalid = '0;
        t3_s_rready = '0; t3_s_bready = '0;
        t3_s_aw = '0; t3_s_w = '0; t3_s_ar = '0;
        t3_m_bvalid = 1'b0; t3_m_b = '0;

        // ---- reset: handshake outputs held low even with requests pending ----
        repeat (2) next_cycle();
        s_arvalid = 2'b11; m_arready = 1'b1;
        #1;
        check_eq("rst_m_arvalid", m_arvalid, 1'b0);
        check_eq("rst_s_arready", s_arready, 2'b00);
        check_eq("rst_m_wvalid", m_wvalid, 1'b0);
        check_eq("rst_err", err_bad_src, 1'b0);
        s_arvalid = 2'b00; m_arready = 1'b0;
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // ---- AR round robin: both requesting, grants alternate ----
        s_ar[0].id = 8'h05; s_ar[0].addr = 32'h0000_1000;
        s_ar[1].id = 8'h07; s_ar[1].addr = 32'h0000_2000;
        s_arvalid = 2'b11; m_arready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq("ar_rr_id", m_ar.id, (k % 2 == 1) ? 64'h87 : 64'h05);
            check_eq("ar_rr_addr", m_ar.addr, (k % 2 == 1) ? 64'h2000 : 64'h1000);
            check_eq("ar_rr_ready", s_arready, (k % 2 == 1) ? 64'h2 : 64'h1);
            next_cycle();
        end

        // ---- AR stall: req1 locked while req0 arrives ----
        s_arvalid = 2'b10; m_arready = 1'b0;
        #1;
        check_eq("ar_stall_first_id", m_ar.id, 8'h87);
        next_cycle();
        s_arvalid = 2'b11;
        for (int k = 0; k < 2; k++) begin
            #1;
            check_eq("ar_lock_id", m_ar.id, 8'h87);
            check_eq("ar_lock_valid", m_arvalid, 1'b1);
            check_eq("ar_lock_ready", s_arready, 2'b00);
            next_cycle();
        end
        m_arready = 1'b1;
        #1;
        check_eq("ar_lock_hs_ready", s_arready, 2'b10);
        next_cycle();
        #1;
        check_eq("ar_after_lock_id", m_ar.id, 8'h05);
        check_eq("ar_after_lock_ready", s_arready, 2'b01);
        s_arvalid = 2'b00; m_arready = 1'b0;
        next_cycle();

        // ---- AW order steers W: req0 burst first even though req1 W is ready ----
        s_aw[0].id = 8'h01; s_aw[0].len = 8'd3;
        s_aw[1].id = 8'h02; s_aw[1].len = 8'd1;
        for (int b = 0; b < 4; b++) exp_q.push_back(64'hA0 + 64'(b));
        for (int b = 0; b < 2; b++) exp_q.push_back(64'hB0 + 64'(b));
        s_awvalid = 2'b01; m_awready = 1'b1; m_wready = 1'b1;
        s_wvalid = 2'b11;
        s_w[0].data = 64'hA0; s_w[0].last = 1'b0;
        s_w[1].data = 64'hB0; s_w[1].last = 1'b0;
        #1;
        check_eq("aw0_valid", m_awvalid, 1'b1);
        check_eq("aw0_id", m_aw.id, 8'h01);
        check_eq("aw0_ready", s_awready, 2'b01);
        check_eq("w_no_bypass", m_wvalid, 1'b0);
        check_eq("w_no_bypass_ready", s_wready, 2'b00);
        next_cycle();
        for (int b = 0; b < 4; b++) begin
            s_awvalid = (b == 0) ? 2'b10 : 2'b00;
            s_w[0].data = 64'hA0 + 64'(b);
            s_w[0].last = (b == 3);
            #1;
            if (b == 0) check_eq("aw1_id", m_aw.id, 8'h82);
            check_eq("w_req0_ready", s_wready, 2'b01);
            check_eq("w_req0_data", m_w.data, exp_q.pop_front());
            next_cycle();
        end
        s_wvalid = 2'b10;
        for (int b = 0; b < 2; b++) begin
            s_w[1].data = 64'hB0 + 64'(b);
            s_w[1].last = (b == 1);
            #1;
            check_eq("w_req1_ready", s_wready, 2'b10);
            check_eq("w_req1_data", m_w.data, exp_q.pop_front());
            next_cycle();
        end
        s_wvalid = 2'b11;
        #1;
        check_eq("w_empty_valid", m_wvalid, 1'b0);
        check_eq("w_empty_ready", s_wready, 2'b00);
        check_eq("w_q_drained", 64'(exp_q.size()), 64'd0);
        s_wvalid = 2'b00; m_wready = 1'b0;
        next_cycle();

        // ---- order FIFO full blocks AW; a pop re-opens it one cycle later ----
        s_awvalid = 2'b01; m_awready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            check_eq("fill_awvalid", m_awvalid, 1'b1);
            next_cycle();
        end
        #1;
        check_eq("full_awvalid", m_awvalid, 1'b0);
        check_eq("full_awready", s_awready, 2'b00);
        s_wvalid = 2'b01; s_w[0].last = 1'b1; m_wready = 1'b1;
        #1;
        check_eq("pop_wready", s_wready, 2'b01);
        check_eq("pop_same_cycle_awvalid", m_awvalid, 1'b0);
        next_cycle();
        #1;
        check_eq("after_pop_awvalid", m_awvalid, 1'b1);
        check_eq("after_pop_awready", s_awready, 2'b01);
        s_awvalid = 2'b00;
        next_cycle();
        repeat (5) next_cycle();
        #1;
        check_eq("drain_last_valid", m_wvalid, 1'b1);
        next_cycle();
        #1;
        check_eq("drain_empty_valid", m_wvalid, 1'b0);
        s_wvalid = 2'b00; m_wready = 1'b0; m_awready = 1'b0;
        next_cycle();

        // ---- R burst to req1 with one upstream stall ----
        m_rvalid = 1'b1; m_r.id = 8'h83; s_rready = 2'b10;
        for (int b = 0; b < 4; b++) begin
            m_r.data = 64'hD0 + 64'(b);
            m_r.last = (b == 3);
            if (b == 2) begin
                s_rready = 2'b00;
                #1;
                check_eq("r_stall_rready", m_rready, 1'b0);
                check_eq("r_stall_valid", s_rvalid, 2'b10);
                next_cycle();
                s_rready = 2'b10;
            end
            #1;
            check_eq("r_valid", s_rvalid, 2'b10);
            check_eq("r_id", s_r[1].id, 8'h03);
            check_eq("r_data", s_r[1].data, 64'hD0 + 64'(b));
            check_eq("r_rready", m_rready, 1'b1);
            next_cycle();
        end
        m_rvalid = 1'b0; s_rready = 2'b00;

        // ---- B to req0 ----
        m_bvalid = 1'b1; m_b.id = 8'h01; s_bready = 2'b01;
        #1;
        check_eq("b_valid", s_bvalid, 2'b01);
        check_eq("b_id", s_b[0].id, 8'h01);
        check_eq("b_bready", m_bready, 1'b1);
        s_bready = 2'b00;
        #1;
        check_eq("b_stall_bready", m_bready, 1'b0);
        next_cycle();
        m_bvalid = 1'b0;
        #1;
        check_eq("no_err_n2", err_bad_src, 1'b0);

        // ---- N_REQ=3: valid tag 2, then bad tag 3 ----
        t3_m_bvalid = 1'b1; t3_m_b.id = 8'h80; t3_s_bready = 3'b100;
        #1;
        check_eq("t3_b_valid", t3_s_bvalid, 3'b100);
        check_eq("t3_b_id", t3_s_b[2].id, 8'h00);
        check_eq("t3_b_bready", t3_m_bready, 1'b1);
        next_cycle();
        #1;
        check_eq("t3_err_clean", t3_err_bad_src, 1'b0);
        t3_m_b.id = 8'hC0; t3_s_bready = 3'b000;
        #1;
        check_eq("t3_bad_sink", t3_m_bready, 1'b1);
        check_eq("t3_bad_no_valid", t3_s_bvalid, 3'b000);
        next_cycle();
        t3_m_bvalid = 1'b0;
        #1;
        check_eq("t3_err_set", t3_err_bad_src, 1'b1);
        next_cycle();
        #1;
        check_eq("t3_err_sticky", t3_err_bad_src, 1'b1);
        rst = 1'b1;
        next_cycle();
        #1;
        check_eq("t3_err_cleared", t3_err_bad_src, 1'b0);
        rst = 1'b0;
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
